// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner with built-in press/release debounce.
// Drives one active-low column at a time and emits one hex code per accepted press.
module keypad_scan_controller #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_sync,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [2:0] {
    ST_SETTLE   = 3'd0,
    ST_SAMPLE   = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_HELD     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [1:0]       col_reg, col_next;
  logic [3:0]       col_n_reg, col_n_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       cand_row_reg, cand_row_next;
  logic [1:0]       cand_col_reg, cand_col_next;
  logic [3:0]       code_reg, code_next;
  logic             valid_reg, valid_next;
  logic             held_reg, held_next;

  logic [3:0] row_low;
  logic       one_low;
  logic [1:0] row_idx;
  logic [3:0] cand_pattern;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Exactly one row low means a single unambiguous key in the driven column.
  assign row_low      = ~row_sync;
  assign one_low      = (row_low != 4'd0) && ((row_low & 4'(row_low - 4'd1)) == 4'd0);
  assign cand_pattern = ~(4'b0001 << cand_row_reg);

  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (row_low[i]) row_idx = 2'(i);
    end
  end

  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    cnt_next      = cnt_reg;
    cand_row_next = cand_row_reg;
    cand_col_next = cand_col_reg;
    code_next     = code_reg;
    valid_next    = 1'b0;
    held_next     = held_reg;

    case (state_reg)
      ST_SETTLE: begin
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = ST_SAMPLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_SAMPLE: begin
        cnt_next = '0;
        if (one_low) begin
          cand_row_next = row_idx;
          cand_col_next = col_reg;
          state_next    = ST_DEBOUNCE;
        end else begin
          // Nothing pressed, or a ghost/multi-press: move on.
          col_next   = col_reg + 2'd1;
          state_next = ST_SETTLE;
        end
      end

      ST_DEBOUNCE: begin
        if (row_sync != cand_pattern) begin
          cnt_next   = '0;
          col_next   = col_reg + 2'd1;
          state_next = ST_SETTLE;
        end else if (cnt_reg == DEB_LAST) begin
          cnt_next   = '0;
          valid_next = 1'b1;
          code_next  = key_map(cand_row_reg, cand_col_reg);
          held_next  = 1'b1;
          state_next = ST_HELD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_HELD: begin
        if (row_sync == 4'b1111) begin
          cnt_next   = '0;
          state_next = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (row_sync != 4'b1111) begin
          cnt_next   = '0;
          state_next = ST_HELD;
        end else if (cnt_reg == DEB_LAST) begin
          cnt_next   = '0;
          held_next  = 1'b0;
          col_next   = col_reg + 2'd1;
          state_next = ST_SETTLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_SETTLE;
        col_next   = 2'd0;
        cnt_next   = '0;
        held_next  = 1'b0;
      end
    endcase

    col_n_next = ~(4'b0001 << col_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_SETTLE;
      col_reg      <= 2'd0;
      col_n_reg    <= 4'b1110;
      cnt_reg      <= '0;
      cand_row_reg <= 2'd0;
      cand_col_reg <= 2'd0;
      code_reg     <= 4'd0;
      valid_reg    <= 1'b0;
      held_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      col_reg      <= col_next;
      col_n_reg    <= col_n_next;
      cnt_reg      <= cnt_next;
      cand_row_reg <= cand_row_next;
      cand_col_reg <= cand_col_next;
      code_reg     <= code_next;
      valid_reg    <= valid_next;
      held_reg     <= held_next;
    end
  end

  assign col_n     = col_n_reg;
  assign key_code  = code_reg;
  assign key_valid = valid_reg;
  assign key_held  = held_reg;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Randomized keypad bench: a physical key matrix model drives the rows, and a
// scoreboard checks each strobe's code and timing against the keypad rules.
module tb_keypad_scan_controller;
  localparam int S = 2;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_sync;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = '0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  logic [3:0] exp_q[$];
  logic [3:0] model_code = 4'd0;
  logic [3:0] prev_col = 4'b1110;
  logic       prev_valid = 1'b0;
  logic       prev_held = 1'b0;
  int         last_change = 0;

  logic [3:0] key_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scan_controller #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D), .CNT_W(18)) dut (
    .clk(clk), .rst(rst), .row_sync(row_sync), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // A pressed key shorts its row to its column; the row reads low when that column is driven.
  always_comb begin
    row_sync = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_sync[r] = 1'b0;
  end

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] v;
    v = 4'b0001 << c;
    return ~v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and watches the invariants.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      model_code  = 4'd0;
      prev_col    = col_n;
      prev_valid  = 1'b0;
      prev_held   = 1'b0;
      last_change = cyc;
    end else begin
      check("col_onehot", $countones(~col_n), 1);
      if (col_n != prev_col) begin
        if (prev_held && key_held) check("col_frozen", col_n, prev_col);
        last_change = cyc;
      end
      if (key_valid) begin
        check("valid_gap", prev_valid, 0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe: got code %0h, expected no strobe (cycle %0d)", key_code, cyc);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("strobe_code", key_code, e);
          check("strobe_latency", cyc - last_change, S + D + 1);
          check("held_at_strobe", key_held, 1);
          model_code = e;
        end
      end else begin
        check("code_hold", key_code, model_code);
        if (!prev_held) check("held_rise_strobe", key_held, 0);
      end
      prev_col   = col_n;
      prev_valid = key_valid;
      prev_held  = key_held;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_held(input logic lvl, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (key_held == lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic press_cycle();
    int r, c, idx, idx2, g, rel;
    bit ok;
    r = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    idx = r*4 + c;
    tick(1);
    exp_q.push_back(key_tbl[idx]);
    pressed[idx] = 1'b1;
    wait_held(1'b1, 4*(S+1) + D + 8, ok);
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL press_timeout: got no strobe, expected key %0h", key_tbl[idx]);
      exp_q.delete();
    end
    tick($urandom_range(1, 10));
    if ($urandom_range(0, 1) == 1) begin
      idx2 = (idx + $urandom_range(1, 15)) % 16;
      pressed[idx2] = 1'b1;
      tick($urandom_range(2, 10));
      check("held_second_key", key_held, 1);
    end
    if ($urandom_range(0, 1) == 1) begin
      pressed = '0;
      g = $urandom_range(1, D - 1);
      tick(g);
      pressed[idx] = 1'b1;
      tick(3);
      check("held_release_glitch", key_held, 1);
    end
    pressed = '0;
    rel = cyc;
    wait_held(1'b0, D + 8, ok);
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL release_timeout: got key_held=1, expected 0");
    end else begin
      check("release_latency", cyc - rel, D + 1);
      check("resume_col", col_n, col_pat((c + 1) % 4));
    end
    tick(2);
  endtask

  task automatic tap();
    int idx;
    idx = $urandom_range(0, 15);
    pressed[idx] = 1'b1;
    tick($urandom_range(1, D));
    pressed = '0;
    tick(D + 4);
    check("tap_no_hold", key_held, 0);
  endtask

  task automatic ghost();
    int c, r1, r2;
    c  = $urandom_range(0, 3);
    r1 = $urandom_range(0, 3);
    r2 = (r1 + $urandom_range(1, 3)) % 4;
    pressed[r1*4+c] = 1'b1;
    pressed[r2*4+c] = 1'b1;
    tick(8*(S+1));
    check("ghost_no_hold", key_held, 0);
    pressed = '0;
    tick(2);
  endtask

  task automatic reset_mid_debounce();
    int r, c;
    bit seen;
    logic [3:0] p;
    r = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    seen = 1'b0;
    p = col_n;
    for (int i = 0; i < 4*(S+1) + 4; i++) begin
      @(negedge clk);
      if (col_n == col_pat(c) && p != col_pat(c)) begin
        seen = 1'b1;
        break;
      end
      p = col_n;
    end
    check("reset_found_col", seen, 1);
    tick(1);
    pressed[r*4+c] = 1'b1;
    tick(S + 3);
    #1 rst = 1'b1;
    #1;
    check("rst_col_n", col_n, 4'b1110);
    check("rst_key_held", key_held, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    pressed = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    bit ok;
    logic [3:0] p;
    #12;
    check("reset_col_n", col_n, 4'b1110);
    check("reset_key_code", key_code, 0);
    check("reset_key_valid", key_valid, 0);
    check("reset_key_held", key_held, 0);
    #10 rst = 1'b0;

    last = -1;
    p = col_n;
    for (int k = 0; k < 5; k++) begin
      ok = 1'b0;
      for (int i = 0; i < S + 4; i++) begin
        @(negedge clk);
        if (col_n != p) begin
          ok = 1'b1;
          break;
        end
      end
      check("idle_col_advance", ok, 1);
      check("idle_col_order", col_n, col_pat((k + 1) % 4));
      if (last >= 0) check("idle_col_period", cyc - last, S + 1);
      last = cyc;
      p = col_n;
    end
    check("idle_no_hold", key_held, 0);

    press_cycle();
    press_cycle();
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 5))
        3: tap();
        4: ghost();
        default: press_cycle();
      endcase
    end
    reset_mid_debounce();
    press_cycle();
    tick(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
- Sequences the 4x4 keypad scan: drives one column at a time, waits for row lines to settle, samples the synchronized rows, then debounces both press and release.
- Emits one registered hex key code per physical press, with a single-cycle valid strobe and a held flag.
- Sits between the row synchronizers and the slide-register/display path, replacing the separate scanner and debouncer with one controller.

Parameters:
- SETTLE_CYCLES, 16, cycles a newly driven column is held before rows are sampled (>=1).
- DEBOUNCE_CYCLES, 240000, consecutive stable cycles required to accept a press or a release (5 ms at 48 MHz, >=2).
- CNT_W, 18, width of the shared settle/debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk, input, 1, system clock (HSOSC domain).
- rst, input, 1, reset; asynchronous, active-high.
- row_sync, input, 4, synchronized row lines; active-low (0 = row pulled low by the driven column).
- col_n, output, 4, column drive; active-low, exactly one bit low at all times.
- key_code, output, 4, hex value of the last accepted key.
- key_valid, output, 1, one-cycle strobe when a new key is accepted.
- key_held, output, 1, high from acceptance until the release is debounced.

Behaviour:
- Reset (async, rst=1): state=SETTLE, column index=0, col_n=4'b1110, counter=0, key_code=0, key_valid=0, key_held=0, candidate row/col=0. All outputs are registered.
- SETTLE: increment counter. At counter==SETTLE_CYCLES-1, clear counter and go to SAMPLE.
- SAMPLE (1 cycle):
  - Exactly one row_sync bit low: latch the row index and the current column as candidate, clear counter, go to DEBOUNCE.
  - No bits low: advance column (3 wraps to 0), go to SETTLE.
  - Two or more bits low: treat as a ghost/multi-press and reject. Advance column, go to SETTLE.
- DEBOUNCE: column frozen.
  - Any cycle where row_sync differs from the latched one-hot-low pattern: abort, clear counter, advance column, go to SETTLE. No output change.
  - Counter reaching DEBOUNCE_CYCLES-1 with the pattern still matching: next cycle key_valid=1 for exactly one cycle, key_code=map(row,col), key_held=1, go to HELD.
- HELD: column frozen; no new keys are accepted, so a second key pressed meanwhile is ignored.
  - row_sync==4'b1111: clear counter, go to RELEASE.
  - Any other pattern: stay in HELD.
- RELEASE:
  - row_sync==4'b1111 for DEBOUNCE_CYCLES consecutive cycles: key_held=0, advance column, go to SETTLE.
  - Any low bit before that: return to HELD, clear counter.
- Key map, code=map(row,col):
  - r0 = 1,2,3,A
  - r1 = 4,5,6,B
  - r2 = 7,8,9,C
  - r3 = E,0,F,D
- key_code holds its value between accepts. key_valid is never high on two consecutive cycles.
- Latency: stable press at the sampled column to key_valid rising = DEBOUNCE_CYCLES+1 cycles after the SAMPLE cycle.
- Worst-case scan period with no key pressed: 4*(SETTLE_CYCLES+1) cycles.
- Counter never wraps; it is cleared on every state entry.
- rst asserted in any state immediately returns to the reset values. A press in progress is discarded with no strobe.
- Illegal state encodings recover to SETTLE with column 0.

Test Plan (SETTLE_CYCLES=2, DEBOUNCE_CYCLES=8):
- Idle, rows 4'b1111 -> col_n cycles 1110,1101,1011,0111,1110 every 3 clocks; key_valid stays 0.
- Hold row1 low only while col_n=1101 (key 5) -> key_valid pulses once 9 cycles after SAMPLE; key_code=4'h5; key_held=1; col_n frozen at 1101.
- Bounce: row2 low on col0 for 5 cycles, high for 1, then low -> DEBOUNCE aborts, no strobe. A later stable press gives key_code=4'h7 with exactly one pulse.
- While holding 5, press 9 (row2 on another column) -> no second strobe. Release all, rows 1111 for 8 cycles -> key_held=0, scanning resumes at col_n=1011.
- Release glitch: rows 1111 for 4 cycles then row1 low -> returns to HELD, key_held stays 1, no strobe.
- Rows 4'b1100 at SAMPLE -> rejected, column advances. Assert rst mid-DEBOUNCE -> col_n=1110, key_held=0, key_code=0 within the same cycle.
